// File: rtl/eight_three_priority_encoder_pkg.sv
// Shared sizes and FSM state encoding for the 8:3 priority encoder.
// Both the arbitration sub-module and the top import this package.
package eight_three_priority_encoder_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/eight_three_priority_encoder_prio_enc8.sv
// Purpose: combinational highest-index encoder of 8 lines into a 3-bit code plus an any flag.
// Latency: zero cycles. Backpressure: none, because it is purely combinational.
module prio_enc8
  import eight_three_priority_encoder_pkg::*;
(
  input  logic [N_REQ-1:0]  req,
  output logic [CODE_W-1:0] code,
  output logic              any
);

  // Ascending scan, so the last set bit seen (the highest index) wins.
  always_comb begin
    code = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) code = CODE_W'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/eight_three_priority_encoder.sv
// Purpose: latches requests into PEND and holds a registered grant code until ACK. Latency: I to VALID is 2 cycles.
// Backpressure: the grant is held stable until ACK and is never preempted; at most one grant is issued per 2 cycles.
module eight_three_priority_encoder
  import eight_three_priority_encoder_pkg::*;
#(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic [N_REQ-1:0]  I,
  input  logic [N_REQ-1:0]  MASK,
  input  logic              ACK,
  output logic [CODE_W-1:0] O,
  output logic              VALID,
  output logic              GS,
  output logic [N_REQ-1:0]  PEND
);

  logic [N_REQ-1:0]  i_d;
  logic [N_REQ-1:0]  set_vec;
  logic [N_REQ-1:0]  clr_vec;
  logic [N_REQ-1:0]  live;
  logic [CODE_W-1:0] win_code;
  logic              win_any;
  state_t            state;

  assign live = PEND & ~MASK;

  prio_enc8 u_enc (
    .req  (live),
    .code (win_code),
    .any  (win_any)
  );

  assign GS = win_any;

  always_comb begin
    set_vec = EDGE_MODE ? (I & ~i_d) : I;
  end

  always_comb begin
    clr_vec = '0;
    if (state == GRANT && ACK) clr_vec[O] = 1'b1;
  end

  // Set is applied after clear, so a same-cycle set on the granted bit wins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PEND <= '0;
      i_d  <= '0;
    end else begin
      PEND <= (PEND & ~clr_vec) | set_vec;
      i_d  <= I;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      O     <= '0;
      VALID <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (EN && win_any) begin
            O     <= win_code;
            VALID <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (ACK) begin
            VALID <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          VALID <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
